acq_readout_seq: RTL and testbench
==================================

ACQ_READOUT_SEQ -- requirements
Module: acq_readout_seq

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 10: sample RAM address width.
REQ-002 SHALL have parameter TMO_BITS, default 28: trigger-wait timeout counter width.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have these ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- go  in  1  single-cycle start-readout request.
- abort  in  1  cancel any operation.
- start_trigger  out  1  one-cycle arm pulse to the acquisition block.
- data_ready  in  1  capture complete.
- trig_point_addr  in  RAM_WIDTH  RAM address of the trigger.
- pretrig  in  RAM_WIDTH  samples stored before the trigger.
- nsmp  in  RAM_WIDTH  samples per channel to send.
- ch_mask  in  4  enabled channels.
- rden  out  1  RAM read enable.
- rdaddress  out  RAM_WIDTH  RAM read address.
- rd_data  in  32  RAM word; byte i is channel i.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  consumer accepts.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  one-cycle pulse when the trigger wait expires.

Function
REQ-005 SHALL implement states IDLE, ARM, WAIT_CLR, WAIT_RDY, RD, CAP, SEND, FIN.
REQ-006 In IDLE, go SHALL latch pretrig, nsmp and ch_mask, then move to ARM; go while busy is ignored.
REQ-007 ARM SHALL assert start_trigger for exactly one cycle, then move to WAIT_CLR.
REQ-008 WAIT_CLR SHALL wait for data_ready=0; WAIT_RDY SHALL wait for data_ready=1. A stale data_ready=1 from a previous capture never starts readout.
REQ-009 In WAIT_CLR and WAIT_RDY, a counter SHALL saturate at 2^TMO_BITS-1. At that value the block pulses timeout and returns to IDLE without done.
REQ-010 On data_ready=1 in WAIT_RDY, the block SHALL set the base address to trig_point_addr-pretrig (mod 2^RAM_WIDTH), select the lowest enabled channel, set the sample index to 0, and go to RD.
REQ-011 RD SHALL assert rden for one cycle with rdaddress = base+index (mod 2^RAM_WIDTH); wrap from 2^RAM_WIDTH-1 to 0 is required.
REQ-012 The RAM has 1-cycle read latency: CAP SHALL register the selected channel byte of rd_data into tx_data, set tx_valid, and go to SEND.
REQ-013 SEND SHALL hold tx_data and tx_valid stable until tx_valid&tx_ready. On that cycle tx_valid drops next cycle and the index increments.
REQ-014 After nsmp samples, the block SHALL advance to the next enabled channel in order 0..3 with index 0. After the last enabled channel it goes to FIN.
REQ-015 Stream order SHALL be channel-major: sample order within a channel starts at base.
REQ-016 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-017 ch_mask=0 or nsmp=0 SHALL emit no bytes and go WAIT_RDY->FIN directly.
REQ-018 abort SHALL force IDLE on the next edge from any state, deasserting tx_valid and rden, with no done or timeout; abort has priority over go.
REQ-019 The block SHALL emit at most one byte per 3 cycles (RD, CAP, SEND); no pipelining is required.

Reset
REQ-020 rstn=0 at a clock edge SHALL give: state IDLE; start_trigger, rden, tx_valid, busy, done, timeout = 0; rdaddress, tx_data = 0; counters = 0.
REQ-021 Reset mid-transfer SHALL discard the transfer; no partial resume.

Configuration
REQ-022 With ACQ_HEADER_EN defined, a HDR state between WAIT_RDY and RD SHALL send 4 bytes under the same handshake: 0xA5, {4'b0,ch_mask}, nsmp[RAM_WIDTH-1:8] zero-extended, nsmp[7:0]. The header is sent even when REQ-017 applies.
REQ-023 Without ACQ_HEADER_EN, HDR SHALL be absent and only sample bytes are sent.

Structure
REQ-024 Package acq_pkg SHALL hold RAM_WIDTH default, the state enum, and the header constant 0xA5.
REQ-025 Sub-module acq_rd_addr_gen (base computation, index counter, wrap, channel selection) is natural; everything else stays in acq_readout_seq.

Verification
REQ-026 trig_point_addr=100, pretrig=10, nsmp=4, ch_mask=0001, tx_ready=1 -> rdaddress 90,91,92,93; bytes = rd_data[7:0] of each; one done pulse.
REQ-027 trig_point_addr=2, pretrig=5, nsmp=6, ch_mask=1010 -> addresses 1021,1022,1023,0,1,2 for channel 1, then the same for channel 3; 12 bytes.
REQ-028 data_ready held at 1 before go -> no RD until data_ready falls and then rises; start_trigger high exactly 1 cycle.
REQ-029 tx_ready toggled randomly at 30% -> tx_data stable whenever tx_valid&!tx_ready; byte count = popcount(ch_mask)*nsmp.
REQ-030 abort asserted during SEND of byte 3 -> next cycle IDLE, tx_valid=0, no done; a following go completes normally.
REQ-031 TMO_BITS=4, data_ready never rises -> timeout pulse 15 cycles after entering the wait, then busy=0.

Source files
------------

// File: rtl/acq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acq_pkg
// Description : Shared types and constants for the acquisition readout
//               sequencer: default RAM address width, FSM state encoding,
//               stream header magic byte and a channel-search helper.
// Revision    : 1.0  initial release
// ============================================================================
package acq_pkg;

  localparam int         C_RAM_WIDTH = 10;
  localparam logic [7:0] C_HDR_MAGIC = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ARM      = 4'd1,
    ST_WAIT_CLR = 4'd2,
    ST_WAIT_RDY = 4'd3,
    ST_HDR      = 4'd4,
    ST_RD       = 4'd5,
    ST_CAP      = 4'd6,
    ST_SEND     = 4'd7,
    ST_FIN      = 4'd8
  } state_t;

  // Lowest enabled channel whose number is >= from; bit 2 flags that one exists.
  function automatic logic [2:0] find_ch(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acq_rd_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : acq_rd_addr_gen
// Description : Readout address generator. Computes the window base from the
//               trigger address and pretrigger depth, walks the sample index
//               with natural wrap of the RAM address space, and steps through
//               the enabled channels in ascending order.
// Revision    : 1.0  initial release
// ============================================================================
module acq_rd_addr_gen
  import acq_pkg::*;
#(
  parameter int RAM_WIDTH = C_RAM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_load,
  input  logic                 i_advance,
  input  logic [RAM_WIDTH-1:0] i_trig_addr,
  input  logic [RAM_WIDTH-1:0] i_pretrig,
  input  logic [RAM_WIDTH-1:0] i_nsmp,
  input  logic [3:0]           i_ch_mask,
  output logic [RAM_WIDTH-1:0] o_addr,
  output logic [1:0]           o_ch,
  output logic                 o_last,
  output logic                 o_empty
);

  logic [RAM_WIDTH-1:0] r_base;
  logic [RAM_WIDTH-1:0] r_idx;
  logic [1:0]           r_ch;
  logic [2:0]           w_first;
  logic [2:0]           w_next;
  logic                 w_idx_last;

  assign w_first    = find_ch(i_ch_mask, 3'd0);
  assign w_next     = find_ch(i_ch_mask, {1'b0, r_ch} + 3'd1);
  assign w_idx_last = (r_idx == i_nsmp - RAM_WIDTH'(1));

  // Address arithmetic is modulo 2^RAM_WIDTH, so the window wraps for free.
  assign o_addr  = r_base + r_idx;
  assign o_ch    = r_ch;
  assign o_last  = w_idx_last && !w_next[2];
  assign o_empty = (i_nsmp == '0) || (i_ch_mask == 4'd0);

  // Base/index/channel registers: load at capture complete, step per sent byte
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_base <= '0;
      r_idx  <= '0;
      r_ch   <= 2'd0;
    end else if (i_load) begin
      r_base <= i_trig_addr - i_pretrig;
      r_idx  <= '0;
      r_ch   <= w_first[2] ? w_first[1:0] : 2'd0;
    end else if (i_advance) begin
      if (w_idx_last) begin
        r_idx <= '0;
        r_ch  <= w_next[1:0];
      end else begin
        r_idx <= r_idx + RAM_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/acq_readout_seq.sv
`default_nettype none
// ============================================================================
// Module      : acq_readout_seq
// Description : Acquisition readout sequencer. Arms the capture block, waits
//               for a fresh capture (with timeout), then streams the selected
//               window of each enabled channel byte-by-byte over a
//               valid/ready interface, channel-major.
//               Optional macro ACQ_HEADER_EN adds a 4-byte stream header.
// Revision    : 1.0  initial release
// ============================================================================
module acq_readout_seq
  import acq_pkg::*;
#(
  parameter int RAM_WIDTH = C_RAM_WIDTH,
  parameter int TMO_BITS  = 28
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 go,
  input  logic                 abort,
  output logic                 start_trigger,
  input  logic                 data_ready,
  input  logic [RAM_WIDTH-1:0] trig_point_addr,
  input  logic [RAM_WIDTH-1:0] pretrig,
  input  logic [RAM_WIDTH-1:0] nsmp,
  input  logic [3:0]           ch_mask,
  output logic                 rden,
  output logic [RAM_WIDTH-1:0] rdaddress,
  input  logic [31:0]          rd_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  state_t               r_state;
  state_t               w_next;
  logic [RAM_WIDTH-1:0] r_pretrig;
  logic [RAM_WIDTH-1:0] r_nsmp;
  logic [3:0]           r_mask;
  logic [TMO_BITS-1:0]  r_tmo;
  logic [7:0]           r_tx_data;
  logic                 w_in_wait;
  logic                 w_next_wait;
  logic                 w_tmo_sat;
  logic                 w_load;
  logic                 w_adv;
  logic                 w_last;
  logic                 w_empty;
  logic [1:0]           w_ch;

  assign w_in_wait   = (r_state == ST_WAIT_CLR) || (r_state == ST_WAIT_RDY);
  assign w_next_wait = (w_next == ST_WAIT_CLR) || (w_next == ST_WAIT_RDY);
  assign w_tmo_sat   = &r_tmo;

  acq_rd_addr_gen #(
    .RAM_WIDTH (RAM_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rstn        (rstn),
    .i_load      (w_load),
    .i_advance   (w_adv),
    .i_trig_addr (trig_point_addr),
    .i_pretrig   (r_pretrig),
    .i_nsmp      (r_nsmp),
    .i_ch_mask   (r_mask),
    .o_addr      (rdaddress),
    .o_ch        (w_ch),
    .o_last      (w_last),
    .o_empty     (w_empty)
  );

`ifdef ACQ_HEADER_EN
  logic [1:0] r_hdr_idx;
  logic [7:0] w_hdr_byte;

  // Header byte selected by position within the 4-byte header
  always_comb begin
    w_hdr_byte = C_HDR_MAGIC;
    case (r_hdr_idx)
      2'd0:    w_hdr_byte = C_HDR_MAGIC;
      2'd1:    w_hdr_byte = {4'b0000, r_mask};
      2'd2:    w_hdr_byte = 8'(r_nsmp >> 8);
      default: w_hdr_byte = 8'(r_nsmp);
    endcase
  end

  // Header position advances on each accepted header byte
  always_ff @(posedge clk) begin
    if (!rstn || r_state != ST_HDR) r_hdr_idx <= 2'd0;
    else if (tx_ready)              r_hdr_idx <= r_hdr_idx + 2'd1;
  end

  assign tx_data  = (r_state == ST_HDR) ? w_hdr_byte : r_tx_data;
  assign tx_valid = (r_state == ST_SEND) || (r_state == ST_HDR);
`else
  assign tx_data  = r_tx_data;
  assign tx_valid = (r_state == ST_SEND);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and address-generator strobes; abort overrides everything
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_adv  = 1'b0;
    case (r_state)
      ST_IDLE:     if (go) w_next = ST_ARM;
      ST_ARM:      w_next = ST_WAIT_CLR;
      // Only a falling data_ready proves the old capture is gone.
      ST_WAIT_CLR: begin
        if (w_tmo_sat)        w_next = ST_IDLE;
        else if (!data_ready) w_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (w_tmo_sat) begin
          w_next = ST_IDLE;
        end else if (data_ready) begin
          w_load = 1'b1;
`ifdef ACQ_HEADER_EN
          w_next = ST_HDR;
`else
          w_next = w_empty ? ST_FIN : ST_RD;
`endif
        end
      end
`ifdef ACQ_HEADER_EN
      ST_HDR:      if (tx_ready && r_hdr_idx == 2'd3) w_next = w_empty ? ST_FIN : ST_RD;
`endif
      ST_RD:       w_next = ST_CAP;
      ST_CAP:      w_next = ST_SEND;
      ST_SEND: begin
        if (tx_ready) begin
          w_adv  = 1'b1;
          w_next = w_last ? ST_FIN : ST_RD;
        end
      end
      ST_FIN:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    if (abort) begin
      w_next = ST_IDLE;
      w_load = 1'b0;
      w_adv  = 1'b0;
    end
  end

  // Configuration latch, trigger-wait counter and captured sample byte
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pretrig <= '0;
      r_nsmp    <= '0;
      r_mask    <= 4'd0;
      r_tmo     <= '0;
      r_tx_data <= 8'd0;
    end else begin
      if (r_state == ST_IDLE && go && !abort) begin
        r_pretrig <= pretrig;
        r_nsmp    <= nsmp;
        r_mask    <= ch_mask;
      end
      // Counter spans both wait states and restarts on every new wait.
      if (w_in_wait && w_next_wait) r_tmo <= r_tmo + 1'b1;
      else                          r_tmo <= '0;
      if (r_state == ST_CAP) r_tx_data <= rd_data[{w_ch, 3'b000} +: 8];
    end
  end

  assign start_trigger = (r_state == ST_ARM);
  assign rden          = (r_state == ST_RD);
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_FIN) && !abort;
  assign timeout       = w_in_wait && w_tmo_sat && !abort;

endmodule
`default_nettype wire

// File: tb/tb_acq_readout_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_acq_readout_seq
// Description : Directed self-checking bench for acq_readout_seq. A RAM model
//               returns a word whose byte i is addr[7:0] + 64*i, so every
//               expected byte follows from its expected address and channel.
// Revision    : 1.0  initial release
// ============================================================================
module tb_acq_readout_seq;

  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          data_ready = 1'b0;
  logic          tx_ready = 1'b1;
  logic [RW-1:0] trig_point_addr = '0;
  logic [RW-1:0] pretrig = '0;
  logic [RW-1:0] nsmp = '0;
  logic [3:0]    ch_mask = 4'd0;
  logic [31:0]   rd_data = 32'd0;
  logic          start_trigger, rden, tx_valid, busy, done, timeout;
  logic [RW-1:0] rdaddress;
  logic [7:0]    tx_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW-1:0] addr_q[$];
  logic [7:0]    byte_q[$];
  int            n_done, n_tmo, n_st, n_stall_err, st_cyc, tmo_cyc;
  int            cyc = 0;
  bit            prev_stall;
  logic [7:0]    prev_data;

  always #5 clk = ~clk;

  acq_readout_seq #(.RAM_WIDTH(RW), .TMO_BITS(4)) dut (
    .clk(clk), .rstn(rstn), .go(go), .abort(abort), .start_trigger(start_trigger),
    .data_ready(data_ready), .trig_point_addr(trig_point_addr), .pretrig(pretrig),
    .nsmp(nsmp), .ch_mask(ch_mask), .rden(rden), .rdaddress(rdaddress),
    .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .timeout(timeout)
  );

  function automatic logic [31:0] ram_word(input logic [RW-1:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'hC0, b + 8'h80, b + 8'h40, b};
  endfunction

  function automatic logic [7:0] ram_byte(input logic [RW-1:0] a, input int ch);
    logic [31:0] w;
    w = ram_word(a);
    return w[8*ch +: 8];
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rden) rd_data <= ram_word(rdaddress);
  end

  // Monitor: record reads, accepted bytes, pulses and stall stability
  always @(negedge clk) begin
    if (rstn) begin
      if (rden) addr_q.push_back(rdaddress);
      if (tx_valid && tx_ready) byte_q.push_back(tx_data);
      if (done) n_done++;
      if (timeout) begin n_tmo++; tmo_cyc = cyc; end
      if (start_trigger) begin n_st++; st_cyc = cyc; end
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) n_stall_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    addr_q.delete(); byte_q.delete();
    n_done = 0; n_tmo = 0; n_st = 0; n_stall_err = 0; prev_stall = 0;
  endtask

  // Pulse go with the given setup, then scramble the setup inputs so that
  // only the latched copies can produce correct results.
  task automatic start_xfer(input int trig, input int pre, input int n, input logic [3:0] mask);
    @(posedge clk); #1;
    trig_point_addr = RW'(trig); pretrig = RW'(pre); nsmp = RW'(n); ch_mask = mask; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0; pretrig = RW'(341); nsmp = RW'(682); ch_mask = 4'hF;
  endtask

  task automatic raise_ready();
    repeat (2) @(posedge clk);
    #1 data_ready = 1'b1;
  endtask

  // mode 0: tx_ready always high; mode 1: random 30% stalls plus a go while busy
  task automatic run_to_done(input int mode, input int budget, output bit expired);
    int c;
    c = 0;
    while (n_done == 0 && n_tmo == 0 && c < budget) begin
      @(posedge clk); #1;
      tx_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) >= 30);
      go = (mode == 1) && (c == 6);
      c++;
    end
    expired = (n_done == 0 && n_tmo == 0);
    go = 1'b0; tx_ready = 1'b1; data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (start_trigger !== 1'b0) begin n_fail++; $display("FAIL rst_start_trigger: got %b want 0", start_trigger); end
    n_tests++; if (rden !== 1'b0)          begin n_fail++; $display("FAIL rst_rden: got %b want 0", rden); end
    n_tests++; if (tx_valid !== 1'b0)      begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    n_tests++; if (done !== 1'b0)          begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_tests++; if (timeout !== 1'b0)       begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    n_tests++; if (rdaddress !== '0)       begin n_fail++; $display("FAIL rst_rdaddress: got %0d want 0", rdaddress); end
    n_tests++; if (tx_data !== 8'd0)       begin n_fail++; $display("FAIL rst_tx_data: got %0d want 0", tx_data); end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic [RW-1:0] ea [4] = '{10'd90, 10'd91, 10'd92, 10'd93};
    bit to;
    clear_mon();
    start_xfer(100, 10, 4, 4'b0001);
    raise_ready();
    run_to_done(0, 200, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_budget: done not seen"); end
    n_tests++; if (addr_q.size() != 4) begin n_fail++; $display("FAIL basic_nread: got %0d want 4", addr_q.size()); end
    n_tests++; if (byte_q.size() != 4) begin n_fail++; $display("FAIL basic_nbyte: got %0d want 4", byte_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < addr_q.size()) begin
        n_tests++; if (addr_q[i] !== ea[i]) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, addr_q[i], ea[i]); end
      end
      if (i < byte_q.size()) begin
        n_tests++; if (byte_q[i] !== ram_byte(ea[i], 0)) begin n_fail++; $display("FAIL basic_byte[%0d]: got %0d want %0d", i, byte_q[i], ram_byte(ea[i], 0)); end
      end
    end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", n_done); end
    n_tests++; if (n_st != 1) begin n_fail++; $display("FAIL basic_start_trigger: got %0d cycles want 1", n_st); end
  endtask

  task automatic test_wrap();
    logic [RW-1:0] ea [6] = '{10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2};
    int chs [2] = '{1, 3};
    bit to;
    int k;
    clear_mon();
    start_xfer(2, 5, 6, 4'b1010);
    raise_ready();
    run_to_done(0, 300, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL wrap_budget: done not seen"); end
    n_tests++; if (byte_q.size() != 12) begin n_fail++; $display("FAIL wrap_nbyte: got %0d want 12", byte_q.size()); end
    n_tests++; if (addr_q.size() != 12) begin n_fail++; $display("FAIL wrap_nread: got %0d want 12", addr_q.size()); end
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 6; i++) begin
        k = c * 6 + i;
        if (k < addr_q.size()) begin
          n_tests++; if (addr_q[k] !== ea[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, addr_q[k], ea[i]); end
        end
        if (k < byte_q.size()) begin
          n_tests++; if (byte_q[k] !== ram_byte(ea[i], chs[c])) begin n_fail++; $display("FAIL wrap_byte[%0d]: got %0d want %0d", k, byte_q[k], ram_byte(ea[i], chs[c])); end
        end
      end
    end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL wrap_done: got %0d pulses want 1", n_done); end
  endtask

  task automatic test_stale_ready();
    bit to;
    clear_mon();
    data_ready = 1'b1;
    start_xfer(300, 0, 3, 4'b0100);
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (addr_q.size() != 0) begin n_fail++; $display("FAIL stale_early_read: got %0d reads want 0", addr_q.size()); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stale_busy: got %b want 1", busy); end
    data_ready = 1'b0;
    raise_ready();
    run_to_done(0, 200, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL stale_budget: done not seen"); end
    n_tests++; if (n_st != 1) begin n_fail++; $display("FAIL stale_start_trigger: got %0d cycles want 1", n_st); end
    n_tests++; if (byte_q.size() != 3) begin n_fail++; $display("FAIL stale_nbyte: got %0d want 3", byte_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < byte_q.size()) begin
        n_tests++; if (byte_q[i] !== ram_byte(RW'(300 + i), 2)) begin n_fail++; $display("FAIL stale_byte[%0d]: got %0d want %0d", i, byte_q[i], ram_byte(RW'(300 + i), 2)); end
      end
    end
  endtask

  task automatic test_random_ready();
    int chs [3] = '{0, 2, 3};
    bit to;
    int k;
    clear_mon();
    start_xfer(50, 3, 5, 4'b1101);
    raise_ready();
    run_to_done(1, 2000, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand_budget: done not seen"); end
    n_tests++; if (byte_q.size() != 15) begin n_fail++; $display("FAIL rand_nbyte: got %0d want 15", byte_q.size()); end
    n_tests++; if (n_stall_err != 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d unstable cycles want 0", n_stall_err); end
    n_tests++; if (n_st != 1) begin n_fail++; $display("FAIL rand_go_busy: got %0d arm cycles want 1", n_st); end
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 5; i++) begin
        k = c * 5 + i;
        if (k < byte_q.size()) begin
          n_tests++; if (byte_q[k] !== ram_byte(RW'(47 + i), chs[c])) begin n_fail++; $display("FAIL rand_byte[%0d]: got %0d want %0d", k, byte_q[k], ram_byte(RW'(47 + i), chs[c])); end
        end
      end
    end
  endtask

  task automatic test_empty();
    bit to;
    logic [3:0] masks [2] = '{4'b0000, 4'b1111};
    int ns [2] = '{4, 0};
    for (int t = 0; t < 2; t++) begin
      clear_mon();
      start_xfer(20, 0, ns[t], masks[t]);
      raise_ready();
      run_to_done(0, 100, to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL empty%0d_budget: done not seen", t); end
      n_tests++; if (byte_q.size() != 0) begin n_fail++; $display("FAIL empty%0d_nbyte: got %0d want 0", t, byte_q.size()); end
      n_tests++; if (addr_q.size() != 0) begin n_fail++; $display("FAIL empty%0d_nread: got %0d want 0", t, addr_q.size()); end
      n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL empty%0d_done: got %0d want 1", t, n_done); end
    end
  endtask

  task automatic test_abort();
    bit to;
    int c;
    clear_mon();
    start_xfer(200, 20, 4, 4'b0011);
    raise_ready();
    c = 0;
    while (byte_q.size() < 2 && c < 50) begin @(posedge clk); #1; c++; end
    tx_ready = 1'b0;
    c = 0;
    while (!tx_valid && c < 10) begin @(posedge clk); #1; c++; end
    n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL abort_reach_send: got tx_valid %b want 1", tx_valid); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_tx_valid: got %b want 0", tx_valid); end
    n_tests++; if (rden !== 1'b0) begin n_fail++; $display("FAIL abort_rden: got %b want 0", rden); end
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (n_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
    n_tests++; if (byte_q.size() != 2) begin n_fail++; $display("FAIL abort_nbyte: got %0d want 2", byte_q.size()); end
    data_ready = 1'b0;
    tx_ready   = 1'b1;
    clear_mon();
    start_xfer(10, 0, 2, 4'b1000);
    raise_ready();
    run_to_done(0, 100, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL abort_rerun_budget: done not seen"); end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL abort_rerun_done: got %0d want 1", n_done); end
    n_tests++; if (byte_q.size() != 2) begin n_fail++; $display("FAIL abort_rerun_nbyte: got %0d want 2", byte_q.size()); end
    if (byte_q.size() == 2) begin
      n_tests++; if (byte_q[1] !== ram_byte(RW'(11), 3)) begin n_fail++; $display("FAIL abort_rerun_byte: got %0d want %0d", byte_q[1], ram_byte(RW'(11), 3)); end
    end
  endtask

  task automatic test_timeout();
    int c;
    clear_mon();
    data_ready = 1'b0;
    start_xfer(0, 0, 4, 4'b0001);
    c = 0;
    while (n_tmo == 0 && c < 40) begin @(posedge clk); #1; c++; end
    n_tests++; if (n_tmo != 1) begin n_fail++; $display("FAIL tmo_pulse: got %0d want 1", n_tmo); end
    n_tests++; if (tmo_cyc - st_cyc != 16) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles after arm want 16", tmo_cyc - st_cyc); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b want 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (n_tmo != 1) begin n_fail++; $display("FAIL tmo_single: got %0d pulses want 1", n_tmo); end
    n_tests++; if (n_done != 0) begin n_fail++; $display("FAIL tmo_no_done: got %0d want 0", n_done); end
  endtask

  task automatic test_reset_mid();
    int c;
    clear_mon();
    start_xfer(5, 0, 8, 4'b0001);
    raise_ready();
    tx_ready = 1'b0;
    c = 0;
    while (!tx_valid && c < 20) begin @(posedge clk); #1; c++; end
    n_tests++; if (tx_data !== 8'd5) begin n_fail++; $display("FAIL rmid_pre_data: got %0d want 5", tx_data); end
    rstn = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_tx_valid: got %b want 0", tx_valid); end
    n_tests++; if (tx_data !== 8'd0) begin n_fail++; $display("FAIL rmid_tx_data: got %0d want 0", tx_data); end
    n_tests++; if (rdaddress !== '0) begin n_fail++; $display("FAIL rmid_rdaddress: got %0d want 0", rdaddress); end
    rstn = 1'b1;
    tx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_no_resume: got busy %b want 0", busy); end
    n_tests++; if (n_done != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d want 0", n_done); end
    data_ready = 1'b0;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_wrap();
    test_stale_ready();
    test_random_ready();
    test_empty();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
